// File: rtl/booth_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : booth_pkg
// Description: Shared types and helpers for the radix-4 Booth multiplier.
//              - state_t       : sequencer states (IDLE, CALC)
//              - booth_digit_t : recoded Booth digit as {neg, one, two}
//              - booth_iter()  : number of Booth digits for a given width
// Revision   : 1.0  initial release
// ============================================================================
package booth_pkg;

   // Sequencer states. One bit is enough for two states.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   // Recoded radix-4 digit.
   // one=1 -> |digit|=1, two=1 -> |digit|=2, neither -> 0.
   // neg selects the negative of the chosen magnitude.
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_digit_t;

   // Operands are extended by two bits before recoding, so WIDTH+2 bits
   // are consumed two at a time: WIDTH/2 + 1 digits.
   function automatic int booth_iter(input int width);
      return width / 2 + 1;
   endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_r4_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : booth_r4_encoder
// Description: Combinational radix-4 Booth recoder. Maps the three
//              overlapping multiplier bits {b[2i+1], b[2i], b[2i-1]} to a
//              signed digit in {-2,-1,0,+1,+2}.
// Ports      :
//   i_bits  in  3  {b[2i+1], b[2i], b[2i-1]}
//   o_neg   out 1  digit is negative
//   o_one   out 1  |digit| = 1
//   o_two   out 1  |digit| = 2
// Revision   : 1.0  initial release
// ============================================================================
module booth_r4_encoder (
   input  logic [2:0] i_bits,
   output logic       o_neg,
   output logic       o_one,
   output logic       o_two
);
   import booth_pkg::*;

   booth_digit_t w_digit;

   always_comb begin
      w_digit = '{neg: 1'b0, one: 1'b0, two: 1'b0};
      case (i_bits)
         3'b000: w_digit = '{neg: 1'b0, one: 1'b0, two: 1'b0}; //  0
         3'b001: w_digit = '{neg: 1'b0, one: 1'b1, two: 1'b0}; // +1
         3'b010: w_digit = '{neg: 1'b0, one: 1'b1, two: 1'b0}; // +1
         3'b011: w_digit = '{neg: 1'b0, one: 1'b0, two: 1'b1}; // +2
         3'b100: w_digit = '{neg: 1'b1, one: 1'b0, two: 1'b1}; // -2
         3'b101: w_digit = '{neg: 1'b1, one: 1'b1, two: 1'b0}; // -1
         3'b110: w_digit = '{neg: 1'b1, one: 1'b1, two: 1'b0}; // -1
         // 111 is -0: keep neg low so the adder sees a clean zero.
         default: w_digit = '{neg: 1'b0, one: 1'b0, two: 1'b0};
      endcase
   end

   assign o_neg = w_digit.neg;
   assign o_one = w_digit.one;
   assign o_two = w_digit.two;

endmodule : booth_r4_encoder
`default_nettype wire

// File: rtl/booth_multiplier_r4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : booth_multiplier_r4
// Description: Iterative radix-4 Booth multiplier, one Booth digit per
//              clock. Signed or unsigned per operation. Result is held
//              until the next completion.
// Parameters :
//   WIDTH        operand width (even, >= 4), default 32
// Ports      :
//   clk          in  1         clock, rising edge
//   sync_rst_n   in  1         synchronous active-low reset
//   valid        in  1         operand strobe, taken when in_ready=1
//   signed_mode  in  1         1 = two's complement, 0 = unsigned
//   A            in  WIDTH     multiplicand
//   B            in  WIDTH     multiplier
//   in_ready     out 1         idle, able to accept operands
//   R            out 2*WIDTH   product, registered
//   done         out 1         one-cycle pulse when R updates
// Revision   : 1.0  initial release
// ============================================================================
module booth_multiplier_r4 #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 sync_rst_n,
   input  logic                 valid,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   R,
   output logic                 done
);
   import booth_pkg::*;

   localparam int ITER   = booth_iter(WIDTH);
   localparam int c_ew   = WIDTH + 2;          // extended operand width
   localparam int c_sw   = WIDTH + 3;          // partial-product / sum width
   localparam int c_cw   = $clog2(ITER);       // digit counter width
   localparam logic [c_cw-1:0] c_last = c_cw'(ITER - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            r_state;
   logic [c_ew-1:0]   r_mcand;   // extended multiplicand
   logic [c_ew-1:0]   r_hi;      // upper accumulator half
   logic [c_ew-1:0]   r_lo;      // multiplier bits being consumed / low product bits
   logic              r_bm1;     // b[2i-1] for the current digit
   logic [c_cw-1:0]   r_cnt;

   // ------------------------------------------------------------------
   // Operand extension. Two extra bits make the unsigned range a
   // positive signed value and let the final digit see a proper sign.
   // ------------------------------------------------------------------
   logic [c_ew-1:0]   w_a_ext;
   logic [c_ew-1:0]   w_b_ext;

   assign w_a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
   assign w_b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

   // ------------------------------------------------------------------
   // Digit recode and partial product
   // ------------------------------------------------------------------
   booth_digit_t      w_digit;

   booth_r4_encoder u_enc (
      .i_bits ({r_lo[1], r_lo[0], r_bm1}),
      .o_neg  (w_digit.neg),
      .o_one  (w_digit.one),
      .o_two  (w_digit.two)
   );

   logic [c_sw-1:0]   w_m1;
   logic [c_sw-1:0]   w_m2;
   logic [c_sw-1:0]   w_sel;
   logic [c_sw-1:0]   w_pp;
   logic [c_sw-1:0]   w_sum;
   logic [c_ew-1:0]   w_hi_nxt;
   logic [c_ew-1:0]   w_lo_nxt;

   assign w_m1  = {r_mcand[c_ew-1], r_mcand};
   assign w_m2  = {r_mcand, 1'b0};
   assign w_sel = w_digit.one ? w_m1 : (w_digit.two ? w_m2 : '0);
   assign w_pp  = w_digit.neg ? (~w_sel + c_sw'(1)) : w_sel;

   // The running upper half is bounded by 2/3 of the multiplicand
   // magnitude, so the sum fits c_sw bits and the shifted value fits
   // back into c_ew bits without loss.
   assign w_sum    = {r_hi[c_ew-1], r_hi} + w_pp;

   // Arithmetic shift of {sum, lo} right by two: the two low sum bits
   // drop into the top of the low half, consumed multiplier bits fall out.
   assign w_hi_nxt = {w_sum[c_sw-1], w_sum[c_sw-1:2]};
   assign w_lo_nxt = {w_sum[1:0], r_lo[c_ew-1:2]};

   assign in_ready = (r_state == IDLE);

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         r_state <= IDLE;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_bm1   <= 1'b0;
         r_cnt   <= '0;
         R       <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid) begin
                  r_mcand <= w_a_ext;
                  r_hi    <= '0;
                  r_lo    <= w_b_ext;
                  r_bm1   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_bm1 <= r_lo[1];
               r_cnt <= r_cnt + c_cw'(1);
               if (r_cnt == c_last) begin
                  // Low 2*WIDTH bits of the final accumulator.
                  R       <= {w_hi_nxt[WIDTH-3:0], w_lo_nxt};
                  done    <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule : booth_multiplier_r4
`default_nettype wire

// File: tb/tb_booth_multiplier_r4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_booth_multiplier_r4
// Description: Scoreboard bench for booth_multiplier_r4 at WIDTH=32 and
//              WIDTH=8. Expected products are pushed when operands are
//              driven and popped when done pulses.
// Revision   : 1.0  initial release
// ============================================================================
module tb_booth_multiplier_r4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   // 32-bit instance
   logic        v32 = 1'b0, m32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        rdy32, done32;
   logic [63:0] r32;

   // 8-bit instance
   logic        v8 = 1'b0, m8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        rdy8, done8;
   logic [15:0] r8;

   booth_multiplier_r4 #(.WIDTH(32)) u_dut32 (
      .clk(clk), .sync_rst_n(rst_n), .valid(v32), .signed_mode(m32),
      .A(a32), .B(b32), .in_ready(rdy32), .R(r32), .done(done32)
   );

   booth_multiplier_r4 #(.WIDTH(8)) u_dut8 (
      .clk(clk), .sync_rst_n(rst_n), .valid(v8), .signed_mode(m8),
      .A(a8), .B(b8), .in_ready(rdy8), .R(r8), .done(done8)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] exp;
      int          stamp;   // index of the accept edge
   } exp_t;

   exp_t        q32[$];
   exp_t        q8[$];
   exp_t        e32, e8;
   logic [63:0] last32 = '0;
   logic [15:0] last8  = '0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic m);
      logic signed [63:0] sa, sb;
      if (m) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic m);
      logic signed [15:0] sa, sb;
      if (m) begin
         sa = {{8{a[7]}}, a};
         sb = {{8{b[7]}}, b};
         return 16'(sa * sb);
      end
      return 16'({8'b0, a} * {8'b0, b});
   endfunction

   // ------------------------------------------------------------------
   // Output monitors
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (done32) begin
            if (q32.size() == 0) begin
               chk_eq("done32_expected", 64'(q32.size()), 64'd1);
            end else begin
               e32 = q32.pop_front();
               chk_eq("R32", r32, e32.exp);
               chk_eq("lat32", 64'(cyc - e32.stamp), 64'd17);
            end
            last32 = r32;
         end else begin
            chk_eq("hold32", r32, last32);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done8) begin
            if (q8.size() == 0) begin
               chk_eq("done8_expected", 64'(q8.size()), 64'd1);
            end else begin
               e8 = q8.pop_front();
               chk_eq("R8", 64'(r8), e8.exp);
               chk_eq("lat8", 64'(cyc - e8.stamp), 64'd5);
            end
            last8 = r8;
         end else begin
            chk_eq("hold8", 64'(r8), 64'(last8));
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic m);
      int n = 0;
      @(negedge clk);
      while (!rdy32 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!rdy32) chk_eq("rdy32_wait", 64'(rdy32), 64'd1);
      v32 = 1'b1; a32 = a; b32 = b; m32 = m;
      q32.push_back('{exp: ref32(a, b, m), stamp: cyc + 1});
      @(negedge clk);
      v32 = 1'b0; a32 = $urandom; b32 = $urandom; m32 = 1'($urandom);
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic m);
      int n = 0;
      @(negedge clk);
      while (!rdy8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy8) chk_eq("rdy8_wait", 64'(rdy8), 64'd1);
      v8 = 1'b1; a8 = a; b8 = b; m8 = m;
      q8.push_back('{exp: 64'(ref8(a, b, m)), stamp: cyc + 1});
      @(negedge clk);
      v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      logic [31:0] ra, rb;
      int          n;

      // Reset state
      repeat (3) @(negedge clk);
      chk_eq("rst_R32",     r32, 64'd0);
      chk_eq("rst_done32",  64'(done32), 64'd0);
      chk_eq("rst_rdy32",   64'(rdy32), 64'd1);
      chk_eq("rst_R8",      64'(r8), 64'd0);
      chk_eq("rst_rdy8",    64'(rdy8), 64'd1);
      rst_n = 1'b1;

      // Directed corner products
      issue32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      issue32(32'h8000_0000, 32'h8000_0000, 1'b1);
      issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      issue32(32'h0000_0000, 32'h8000_0000, 1'b1);
      issue32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

      // Sign-quadrant sweep, both modes
      for (int md = 0; md < 2; md++) begin
         for (int qd = 0; qd < 4; qd++) begin
            for (int i = 0; i < 130; i++) begin
               ra = $urandom;
               rb = $urandom;
               ra[31] = qd[0];
               rb[31] = qd[1];
               issue32(ra, rb, md[0]);
            end
         end
      end

      // Handshake: a strobe during CALC is ignored
      issue32(32'd3, 32'd4, 1'b0);
      @(negedge clk);
      @(negedge clk);
      v32 = 1'b1; a32 = 32'd5; b32 = 32'd7; m32 = 1'b0;
      @(negedge clk);
      v32 = 1'b0;
      // Strobe held on the done cycle is taken
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done32 && n < 40);
      chk_eq("done32_seen", 64'(done32), 64'd1);
      chk_eq("rdy_on_done", 64'(rdy32), 64'd1);
      v32 = 1'b1; a32 = 32'd5; b32 = 32'd7; m32 = 1'b0;
      q32.push_back('{exp: 64'd35, stamp: cyc + 1});
      @(negedge clk);
      v32 = 1'b0;

      // Reset in the middle of an operation
      issue32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_eq("midrst_R32",    r32, 64'd0);
      chk_eq("midrst_done32", 64'(done32), 64'd0);
      chk_eq("midrst_rdy32",  64'(rdy32), 64'd1);
      chk_eq("midrst_R8",     64'(r8), 64'd0);
      q32.delete();
      last32 = '0;
      last8  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      issue32(32'd2, 32'd3, 1'b1);

      // 8-bit instance
      issue8(8'h80, 8'h7F, 1'b1);
      issue8(8'hFF, 8'hFF, 1'b0);
      issue8(8'h80, 8'h80, 1'b1);
      issue8(8'hFF, 8'hFF, 1'b1);
      for (int i = 0; i < 200; i++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom));
      end

      // Drain outstanding results
      n = 0;
      while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk_eq("drain32", 64'(q32.size()), 64'd0);
      chk_eq("drain8",  64'(q8.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_booth_multiplier_r4
`default_nettype wire

// File: doc/booth_multiplier_r4.md
# booth_multiplier_r4

Parametrised iterative radix-4 Booth multiplier; successor to the fixed 32-bit unit. It adds operand width as a parameter and a per-operation signed/unsigned mode. It also adds an explicit input-ready/result-done handshake, and results are held until the next completion. It sits in the arithmetic library as a drop-in sequential multiplier for datapaths that can tolerate multi-cycle latency.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 4.
- `ITER`, derived = WIDTH/2 + 1: Booth digits per operation; not overridable.
- `clk`  in  1: single clock; all state updates on rising edge.
- `sync_rst_n`  in  1: reset, synchronous, active-low.
- `valid`  in  1: operand strobe; accepted only when `in_ready`=1.
- `signed_mode`  in  1: 1 = both operands two's complement; 0 = both unsigned; sampled with operands.
- `A`  in  WIDTH: multiplicand.
- `B`  in  WIDTH: multiplier.
- `in_ready`  out  1: high when idle; combinational from state.
- `R`  out  2*WIDTH: product, registered, held until next completion.
- `done`  out  1: one-cycle pulse when `R` updates.

## Operation
- States: IDLE, CALC. Reset → IDLE; `R`=0, `done`=0, `in_ready`=1, counter=0, internal registers=0.
- IDLE: `in_ready`=1. On an edge with `valid`=1:
  - capture A and B, each extended to WIDTH+2 bits (sign-extended if `signed_mode`, else zero-extended);
  - clear accumulator; counter=0; → CALC.
  - Otherwise hold.
- CALC: `in_ready`=0; `valid` ignored (no queuing, no error). Each edge:
  - take Booth digit from multiplier bits {b[2i+1], b[2i], b[2i−1]} with b[−1]=0;
  - digit ∈ {−2,−1,0,+1,+2}; add digit×multiplicand (width WIDTH+3, two's complement) into the upper accumulator;
  - arithmetic-shift accumulator+multiplier right by 2;
  - counter++.
- On the edge where counter reaches ITER−1: `R` ← low 2*WIDTH bits of the final accumulator, `done` ← 1, → IDLE.
- Width rules:
  - accumulator is 2*WIDTH+4 bits, so no intermediate overflow;
  - the result is exact for all inputs in both modes, including −2^(WIDTH−1) × −2^(WIDTH−1) signed and (2^WIDTH−1)² unsigned.
- `done` is deasserted on every edge where it is not set.
- `R` changes only on completion or reset.

## Timing
- Accept edge k. CALC edges are k+1 … k+ITER, and `R`/`done` are valid in the cycle after edge k+ITER. Latency is ITER cycles after the accept edge; 17 for WIDTH=32.
- `in_ready` is low from after edge k through edge k+ITER. It is high in the same cycle `done` is high, so back-to-back acceptance is allowed in that cycle.
- Throughput: one operation per ITER+1 cycles.
- Reset mid-CALC: the next edge with `sync_rst_n`=0 aborts the operation. State → IDLE, `R`=0, `done`=0, and no partial result is published.
- Reset has priority over a simultaneous `valid`.
- Operand inputs may change freely after the accept edge.

## Structure
- Package `booth_pkg`:
  - state enum (IDLE, CALC);
  - Booth digit encoding struct {neg, one, two};
  - function computing ITER from WIDTH.
- Sub-module `booth_r4_encoder`: combinational; 3 multiplier bits → {neg, one, two}. Instantiated once; the main module selects ±multiplicand / ±2×multiplicand from its output.
- Counter width is $clog2(ITER).

## Test plan
- WIDTH=32, signed: 0x7FFFFFFF × 0x7FFFFFFF → `R`=0x3FFFFFFF00000001, `done` pulses exactly 17 cycles after accept. Then 0x80000000 × 0x80000000 → 0x4000000000000000.
- WIDTH=32, unsigned: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001. The same operands in signed mode → 0x0000000000000001.
- WIDTH=32 mixed-sign random sweep in four sign quadrants, both modes (≥1000 ops): `R` equals the reference product every time, and `R` is stable between `done` pulses.
- Handshake: `valid` pulsed with A=5, B=7 during CALC of 3×4 → `R`=12, second request ignored. `valid` held high on the `done` cycle with A=5, B=7 → accepted, `R`=35 after 17 cycles.
- Reset mid-op: `sync_rst_n` low at CALC cycle 8 → `R`=0, `done`=0, `in_ready`=1 after that edge. Next operation 2×3 → 6.
- WIDTH=8 instance, ITER=5, signed: 0x80 × 0x7F → 0xC080. Unsigned: 0xFF × 0xFF → 0xFE01. Latency is 5 cycles.
